// File: rtl/m_mem_access.sv
// ============================================================================
// m_mem_access
// ----------------------------------------------------------------------------
// Memory-stage consumer of the EX/MEM pipeline register. It decodes the
// latched instruction and issues one registered request per load or store to
// a data memory over a req/ack handshake. It returns extended load data to
// the write-back stage.
//
// The stall output freezes the EX/MEM register and every earlier stage. A
// memory op therefore occupies this stage for IDLE -> BUSY (one or more
// cycles) -> DONE. A non-memory op passes through in a single cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; returns the FSM to IDLE at once
//   instr        instruction held in the EX/MEM register
//   ao           ALU output, which is the effective byte address
//   rd2          forwarded store data
//   stall        1 = hold EX/MEM and the upstream stages
//   mem_req      registered request strobe to the data memory
//   mem_we       1 = store, 0 = load (meaningful while mem_req = 1)
//   mem_addr     word-aligned request address
//   mem_byteen   store byte lanes
//   mem_wdata    lane-replicated store data
//   mem_ack      memory completion; mem_rdata is valid in the same cycle
//   mem_rdata    word read data
//   ld_data      extended load result (valid while ld_valid = 1)
//   ld_valid     one-cycle pulse in DONE for loads
//   adel         combinational load-misalignment flag
//   ades         combinational store-misalignment flag
//   timeout_err  one-cycle pulse in DONE when no ack arrived in time
//
// Parameter:
//   TIMEOUT_CYCLES  number of BUSY cycles without mem_ack before the access
//                   is abandoned (must be >= 2)
// ============================================================================
module m_mem_access #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] ao,
    input  logic [31:0] rd2,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        adel,
    output logic        ades,
    output logic        timeout_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam int              CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Decode of the current EX/MEM instruction
    // ------------------------------------------------------------------------
    logic [5:0] opcode;
    logic       is_load;
    logic       is_store;
    logic       is_half;
    logic       is_word;
    logic       go;
    logic       unused_instr;

    assign opcode = instr[31:26];

    // Only the opcode field matters here; the remaining instruction bits
    // are reduced into a sink signal so that they are not left dangling.
    assign unused_instr = ^instr[25:0];

    assign is_load  = (opcode == OP_LW) || (opcode == OP_LB) || (opcode == OP_LBU) ||
                      (opcode == OP_LH) || (opcode == OP_LHU);
    assign is_store = (opcode == OP_SW) || (opcode == OP_SB) || (opcode == OP_SH);
    assign is_half  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
    assign is_word  = (opcode == OP_LW) || (opcode == OP_SW);

    // Halfwords need bit 0 clear. Words need both low bits clear. Bytes can
    // never be misaligned.
    assign adel = is_load  && ((is_half && ao[0]) || (is_word && (ao[1:0] != 2'b00)));
    assign ades = is_store && ((is_half && ao[0]) || (is_word && (ao[1:0] != 2'b00)));
    assign go   = (is_load || is_store) && !adel && !ades;

    // ------------------------------------------------------------------------
    // Store lane steering (computed from the live instruction and captured on
    // the IDLE -> BUSY edge)
    // ------------------------------------------------------------------------
    logic [3:0]  lane_hit;
    logic [3:0]  byteen_next;
    logic [31:0] wdata_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign lane_hit[gi] = (ao[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        byteen_next = 4'b0000;
        wdata_next  = 32'h0;
        case (opcode)
            OP_SB: begin
                byteen_next = lane_hit;
                wdata_next  = {4{rd2[7:0]}};
            end
            OP_SH: begin
                byteen_next = ao[1] ? 4'b1100 : 4'b0011;
                wdata_next  = {2{rd2[15:0]}};
            end
            OP_SW: begin
                byteen_next = 4'b1111;
                wdata_next  = rd2;
            end
            default: begin
                byteen_next = 4'b0000;
                wdata_next  = 32'h0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered request and access context
    // ------------------------------------------------------------------------
    logic             mem_req_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [3:0]       mem_byteen_reg;
    logic [31:0]      mem_wdata_reg;
    logic [31:0]      ld_data_reg;
    logic             ld_valid_reg;
    logic             timeout_err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [5:0]       op_reg;      // opcode of the access in flight
    logic [1:0]       off_reg;     // byte offset of the access in flight

    // The extension uses the registered opcode and offset. The EX/MEM
    // contents are not consulted once the request has been launched.
    logic [7:0]  rdata_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ld_ext;
    logic        load_in_flight;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_load_lane
            assign rdata_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte       = rdata_byte[off_reg];
    assign sel_half       = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign load_in_flight = !mem_we_reg;

    always_comb begin
        ld_ext = mem_rdata;
        case (op_reg)
            OP_LB:   ld_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  ld_ext = {24'h0, sel_byte};
            OP_LH:   ld_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  ld_ext = {16'h0, sel_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // BUSY-cycle events
    logic busy_ack;
    logic busy_timeout;

    assign busy_ack     = (state_reg == BUSY) && mem_ack;
    assign busy_timeout = (state_reg == BUSY) && !mem_ack && (cnt_reg == CNT_MAX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = go ? BUSY : IDLE;
            BUSY:    state_next = (busy_ack || busy_timeout) ? DONE : BUSY;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // The stall is forced low while reset is held. An access that is
    // abandoned by reset then releases the pipeline before the next edge,
    // even if the EX/MEM register still holds a memory op.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE:    stall = go;
                BUSY:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= 32'h0;
            mem_byteen_reg  <= 4'b0000;
            mem_wdata_reg   <= 32'h0;
            ld_data_reg     <= 32'h0;
            ld_valid_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
            cnt_reg         <= '0;
            op_reg          <= 6'h0;
            off_reg         <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    ld_valid_reg    <= 1'b0;
                    timeout_err_reg <= 1'b0;
                    if (go) begin
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= is_store;
                        mem_addr_reg   <= {ao[31:2], 2'b00};
                        mem_byteen_reg <= byteen_next;
                        mem_wdata_reg  <= wdata_next;
                        op_reg         <= opcode;
                        off_reg        <= ao[1:0];
                        cnt_reg        <= '0;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (busy_ack) begin
                        mem_req_reg <= 1'b0;
                        if (load_in_flight) begin
                            ld_data_reg  <= ld_ext;
                            ld_valid_reg <= 1'b1;
                        end
                    end else if (busy_timeout) begin
                        // The access is abandoned and a load returns zero.
                        mem_req_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        ld_data_reg     <= 32'h0;
                        ld_valid_reg    <= load_in_flight;
                    end
                end
                DONE: begin
                    // These are single-cycle pulses, cleared on the way back
                    // to IDLE.
                    ld_valid_reg    <= 1'b0;
                    timeout_err_reg <= 1'b0;
                end
                default: begin
                    mem_req_reg     <= 1'b0;
                    ld_valid_reg    <= 1'b0;
                    timeout_err_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_byteen  = mem_byteen_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign ld_data     = ld_data_reg;
    assign ld_valid    = ld_valid_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_m_mem_access.sv
// ============================================================================
// tb_m_mem_access
// ----------------------------------------------------------------------------
// Self-checking bench for m_mem_access with a short timeout (4 cycles).
// When an op is driven, the bench pushes the expected request fields and the
// expected load result onto queues. They are popped and compared when the
// DUT raises mem_req and when it reaches DONE.
// ============================================================================
module tb_m_mem_access;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam int         NO_ACK = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] ao;
    logic [31:0] rd2;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        adel;
    logic        ades;
    logic        timeout_err;

    always #5 clk = ~clk;

    m_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .ao          (ao),
        .rd2         (rd2),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_byteen  (mem_byteen),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .adel        (adel),
        .ades        (ades),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    req_t        req_q [$];
    logic [31:0] ld_q  [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic bit is_ld(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [1:0] o);
        if (op == OP_SW) return 4'b1111;
        if (op == OP_SH) return (o >= 2'd2) ? 4'b1100 : 4'b0011;
        if (op == OP_SB) begin
            case (o)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        return 4'b0000;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [5:0] op, input logic [31:0] d);
        if (op == OP_SW) return d;
        if (op == OP_SH) return {d[15:0], d[15:0]};
        if (op == OP_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [5:0] op, input logic [1:0] o,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = (o >= 2'd2) ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return h[15] ? {16'hFFFF, h} : {16'h0, h};
            OP_LHU:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // One complete memory op. It is entered one time unit after a rising edge
    // with the DUT in IDLE, and it returns at the same phase with the DUT back
    // in IDLE. An ack_dly of NO_ACK never acknowledges, which forces a
    // timeout.
    // ------------------------------------------------------------------------
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int ack_dly);
        req_t r;
        bit   ld;
        bit   tmo;
        int   cyc;
        ld  = is_ld(op);
        tmo = (ack_dly == NO_ACK);

        instr     = {op, 26'h0};
        ao        = a;
        rd2       = d;
        mem_rdata = rd;
        mem_ack   = 1'b0;

        r.we   = !ld;
        r.addr = {a[31:2], 2'b00};
        r.be   = exp_be(op, a[1:0]);
        r.wd   = exp_wd(op, d);
        req_q.push_back(r);
        if (ld) ld_q.push_back(tmo ? 32'h0 : exp_ld(op, a[1:0], rd));

        // IDLE cycle: the stall is raised combinationally and no request is
        // made yet.
        @(negedge clk);
        chk("stall_idle", {31'h0, stall}, 32'h1);
        chk("req_idle", {31'h0, mem_req}, 32'h0);

        // First BUSY cycle: the request is visible.
        @(negedge clk);
        chk("req_busy", {31'h0, mem_req}, 32'h1);
        chk("stall_busy", {31'h0, stall}, 32'h1);
        r = req_q.pop_front();
        chk("mem_we", {31'h0, mem_we}, {31'h0, r.we});
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_byteen", {28'h0, mem_byteen}, {28'h0, r.be});
        if (!ld) chk("mem_wdata", mem_wdata, r.wd);

        if (!tmo) begin
            repeat (ack_dly) begin
                @(negedge clk);
                chk("stall_wait", {31'h0, stall}, 32'h1);
                chk("req_wait", {31'h0, mem_req}, 32'h1);
            end
            mem_ack = 1'b1;
            @(posedge clk);
            #1 mem_ack = 1'b0;
            @(negedge clk);
        end else begin
            cyc = 1;
            while (mem_req && cyc < 12) begin
                @(negedge clk);
                if (mem_req) cyc++;
            end
            chk("req_cycles", cyc, 4);
        end

        // DONE cycle
        chk("stall_done", {31'h0, stall}, 32'h0);
        chk("req_done", {31'h0, mem_req}, 32'h0);
        chk("timeout_err", {31'h0, timeout_err}, {31'h0, tmo});
        if (ld) begin
            if (!tmo) chk("ld_valid", {31'h0, ld_valid}, 32'h1);
            chk("ld_data", ld_data, ld_q.pop_front());
        end else begin
            chk("ld_valid_st", {31'h0, ld_valid}, 32'h0);
        end
        $display("op=%b ao=%h rd2=%h rdata=%h ack_dly=%0d -> addr=%h be=%b ld=%h to=%b",
                 op, a, d, rd, ack_dly, mem_addr, mem_byteen, ld_data, timeout_err);

        @(posedge clk);
        #1 instr = {OP_NOP, 26'h0};
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [5:0] op_tab [8];

    initial begin
        op_tab[0] = OP_LW;  op_tab[1] = OP_LB;  op_tab[2] = OP_LBU; op_tab[3] = OP_LH;
        op_tab[4] = OP_LHU; op_tab[5] = OP_SW;  op_tab[6] = OP_SB;  op_tab[7] = OP_SH;

        reset     = 1'b1;
        instr     = {OP_NOP, 26'h0};
        ao        = 32'h0;
        rd2       = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Reset values are checked before any clock edge.
        #2;
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", {28'h0, mem_byteen}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        chk("rst_tmo", {31'h0, timeout_err}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // T1: lw
        run_op(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        // T2: lb, lbu
        run_op(OP_LB,  32'h13, 32'h0, 32'h80112233, 0);
        run_op(OP_LBU, 32'h13, 32'h0, 32'h80112233, 1);
        // T3: sb, sh
        run_op(OP_SB, 32'h21, 32'h000000AB, 32'h0, 0);
        run_op(OP_SH, 32'h22, 32'h00001234, 32'h0, 2);
        // Halfword sign extension, then back-to-back identical ops
        run_op(OP_LH,  32'h42, 32'h0, 32'h9ABC1234, 0);
        run_op(OP_LHU, 32'h42, 32'h0, 32'h9ABC1234, 0);
        run_op(OP_LHU, 32'h42, 32'h0, 32'h9ABC1234, 0);

        // A stray ack while IDLE with a non-memory op is ignored.
        instr   = {OP_NOP, 26'h0};
        mem_ack = 1'b1;
        @(negedge clk);
        chk("nop_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("nop_req", {31'h0, mem_req}, 32'h0);
        chk("nop_ld_valid", {31'h0, ld_valid}, 32'h0);
        @(posedge clk);
        #1;

        // T4: misaligned lw and sh
        instr = {OP_LW, 26'h0};
        ao    = 32'h2;
        @(negedge clk);
        chk("adel_lw", {31'h0, adel}, 32'h1);
        chk("ades_lw", {31'h0, ades}, 32'h0);
        chk("stall_adel", {31'h0, stall}, 32'h0);
        @(negedge clk);
        chk("req_adel", {31'h0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        instr = {OP_SH, 26'h0};
        ao    = 32'h1;
        @(negedge clk);
        chk("ades_sh", {31'h0, ades}, 32'h1);
        chk("adel_sh", {31'h0, adel}, 32'h0);
        chk("stall_ades", {31'h0, stall}, 32'h0);
        @(negedge clk);
        chk("req_ades", {31'h0, mem_req}, 32'h0);
        @(posedge clk);
        #1;

        // T5: timeout on a load
        run_op(OP_LW, 32'h50, 32'h0, 32'h12345678, NO_ACK);

        // T6: reset asserted between edges while a request is outstanding
        instr = {OP_LW, 26'h0};
        ao    = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk("t6_req_before", {31'h0, mem_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_req_reset", {31'h0, mem_req}, 32'h0);
        chk("t6_stall_reset", {31'h0, stall}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        instr = {OP_NOP, 26'h0};
        @(posedge clk);
        #1;
        run_op(OP_SW, 32'h64, 32'hCAFEF00D, 32'h0, 0);

        // Random aligned ops
        for (int k = 0; k < 20; k++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = op_tab[$urandom_range(0, 7)];
            a  = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            if (op == OP_LW || op == OP_SW) a[1:0] = 2'b00;
            if (op == OP_LH || op == OP_LHU || op == OP_SH) a[0] = 1'b0;
            run_op(op, a, $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
